vscale_hasti_rr_arbiter: RTL

- Parametrised N-master to 1-slave HASTI (AHB-lite) data-memory arbiter. It replaces the externally steered two-port arbiter between the core dmem ports and port 0 of the dual-port SRAM.
- Selectable grant policy: external index, round-robin, or fixed priority.
- Grant changes only at transfer-safe boundaries, so no data phase ever crosses a master switch.
- A saturating contention counter is provided for performance monitoring.

---
 rtl/vscale_hasti_rr_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vscale_hasti_rr_arbiter.sv
// N-master to 1-slave HASTI data-memory arbiter with a selectable grant policy.
// The grant only moves on cycles where no data phase can straddle the switch.
module vscale_hasti_rr_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_WIDTH   = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned BUS_WIDTH   = 32,
    parameter int unsigned MODE        = 1,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr,
    input  logic [NUM_MASTERS-1:0]            m_hwrite,
    input  logic [NUM_MASTERS*3-1:0]          m_hsize,
    input  logic [NUM_MASTERS*2-1:0]          m_htrans,
    input  logic [NUM_MASTERS*BUS_WIDTH-1:0]  m_hwdata,
    output logic [NUM_MASTERS*BUS_WIDTH-1:0]  m_hrdata,
    output logic [NUM_MASTERS-1:0]            m_hready,
    output logic [NUM_MASTERS-1:0]            m_hresp,
    output logic [ADDR_WIDTH-1:0]             s_haddr,
    output logic                              s_hwrite,
    output logic [2:0]                        s_hsize,
    output logic [1:0]                        s_htrans,
    output logic [BUS_WIDTH-1:0]              s_hwdata,
    input  logic [BUS_WIDTH-1:0]              s_hrdata,
    input  logic                              s_hready,
    input  logic                              s_hresp,
    input  logic [IDX_WIDTH-1:0]              next_core,
    output logic [IDX_WIDTH-1:0]              grant,
    output logic [CNT_WIDTH-1:0]              contention_count
);

    localparam int unsigned MODE_EXT   = 0;
    localparam int unsigned MODE_RR    = 1;
    localparam int unsigned MODE_FIXED = 2;

    localparam logic [1:0]           HTRANS_IDLE = 2'b00;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(NUM_MASTERS - 1);

    logic [IDX_WIDTH-1:0] grant_q, grant_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic                 dvalid_q, dvalid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] sel;
    logic [NUM_MASTERS-1:0] rr_mask;
    logic                   req_owner;
    logic                   others_req;
    logic                   boundary;

    logic                 fp_found;
    logic                 rr_found;
    logic                 ext_ok;
    logic [IDX_WIDTH-1:0] fp_idx;
    logic [IDX_WIDTH-1:0] rr_hi_idx;
    logic [IDX_WIDTH-1:0] rr_idx;

    // Request, owner-select and round-robin "above the pointer" masks.
    always_comb begin
        req     = '0;
        sel     = '0;
        rr_mask = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req[i]     = m_htrans[2*i+1];
            sel[i]     = (grant_q == IDX_WIDTH'(i));
            rr_mask[i] = (IDX_WIDTH'(i) > rr_ptr_q);
        end
    end

    assign req_owner  = |(req & sel);
    assign others_req = |(req & ~sel);
    assign boundary   = s_hready & ~req_owner;

    // Downward scans leave the lowest matching index; round-robin first looks strictly
    // above the pointer and wraps to the lowest requester overall.
    always_comb begin
        fp_found  = 1'b0;
        fp_idx    = grant_q;
        rr_found  = 1'b0;
        rr_hi_idx = grant_q;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) begin
                fp_found = 1'b1;
                fp_idx   = IDX_WIDTH'(i);
            end
            if (req[i] && rr_mask[i]) begin
                rr_found  = 1'b1;
                rr_hi_idx = IDX_WIDTH'(i);
            end
        end
        rr_idx = rr_found ? rr_hi_idx : fp_idx;
    end

    assign ext_ok = (32'(next_core) < NUM_MASTERS);

    always_comb begin
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        dvalid_d = s_hready ? req_owner : dvalid_q;
        cnt_d    = cnt_q;
        if (others_req && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        if (boundary) begin
            case (MODE)
                MODE_EXT: begin
                    if (ext_ok) grant_d = next_core;
                end
                MODE_RR: begin
                    if (fp_found) begin
                        grant_d  = rr_idx;
                        rr_ptr_d = rr_idx;
                    end
                end
                MODE_FIXED: begin
                    if (fp_found) grant_d = fp_idx;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q  <= '0;
            rr_ptr_q <= LAST_IDX;
            dvalid_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            dvalid_q <= dvalid_d;
            cnt_q    <= cnt_d;
            // A stalled data phase must keep its owner on the bus.
            if (dvalid_q && !s_hready) begin
                assert (grant_d == grant_q);
            end
        end
    end

    // Address and write-data mux; the data-phase owner always equals grant_q.
    always_comb begin
        s_haddr  = '0;
        s_hwrite = 1'b0;
        s_hsize  = '0;
        s_htrans = HTRANS_IDLE;
        s_hwdata = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (sel[i]) begin
                s_haddr  = m_haddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_hwrite = m_hwrite[i];
                s_hsize  = m_hsize[i*3 +: 3];
                s_htrans = m_htrans[i*2 +: 2];
                s_hwdata = m_hwdata[i*BUS_WIDTH +: BUS_WIDTH];
            end
        end
        if (reset) s_htrans = HTRANS_IDLE;
    end

    always_comb begin
        m_hrdata = {NUM_MASTERS{s_hrdata}};
        m_hready = '1;
        m_hresp  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_hready[i] = sel[i] ? s_hready : ~req[i];
            m_hresp[i]  = sel[i] & s_hresp;
        end
        if (reset) begin
            m_hready = '1;
            m_hresp  = '0;
        end
    end

    assign grant            = grant_q;
    assign contention_count = cnt_q;

endmodule
